// File: rtl/stbus_frame_tx_pkg.sv
// Shared constants and types for the ST-BUS frame transmitter.
// One frame is 1024 C4 half-periods (ph), each bit cell is 4 ph long,
// each channel is 8 bits, so a channel spans 32 ph.
package stbus_pkg;

  // Frame geometry
  localparam int PH_PER_FRAME = 1024;
  localparam int BITS_PER_CH  = 8;
  localparam int CHANNELS     = 32;
  localparam int PH_PER_BIT   = 4;

  // Derived widths
  localparam int PH_W   = $clog2(PH_PER_FRAME);
  localparam int CH_W   = $clog2(CHANNELS);
  localparam int BYTE_W = BITS_PER_CH;

  // Low ph bits that are zero at the start of a bit cell / a channel
  localparam int CELL_LSB = $clog2(PH_PER_BIT);
  localparam int CHAN_LSB = $clog2(PH_PER_BIT * BITS_PER_CH);

  // Byte shown on idle / unwritten channels
  localparam logic [BYTE_W-1:0] IDLE_BYTE = 8'hFF;

  // Transmitter run state: ST_IDLE while en is low (or after reset),
  // ST_RUN once en has been sampled high.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tx_state_e;

endpackage

// File: rtl/stbus_frame_tx_if.sv
// Host + line-side signal bundle of the ST-BUS transmitter.
// Handshake semantics: wr and commit are single-cycle strobes sampled on
// every clk rising edge; there is no backpressure, so every strobe sampled
// high is accepted (a commit while pend=1 is simply absorbed).
// The transmitter itself uses the master modport; the host/bench side of
// the bundle is described by the slave modport.
interface stbus_frame_tx_if;
  import stbus_pkg::*;

  // host side
  logic              en;
  logic              wr;
  logic [CH_W-1:0]   waddr;
  logic [BYTE_W-1:0] wdata;
  logic              commit;
  logic              pend;

  // ST-BUS line side
  logic              c4;
  logic              f0_n;
  logic              dsto;
  logic              frame_tick;
  logic [CH_W-1:0]   chan;

  // debug view of the run state
  tx_state_e         state;

  modport master (
    input  en, wr, waddr, wdata, commit,
    output pend, c4, f0_n, dsto, frame_tick, chan, state
  );

  modport slave (
    output en, wr, waddr, wdata, commit,
    input  pend, c4, f0_n, dsto, frame_tick, chan, state
  );

endinterface

// File: rtl/stbus_tx_bank.sv
// Double-buffered channel store: two banks of 32 bytes. The host writes
// into the inactive bank; the transmitter reads the active bank. A swap
// toggles which bank is active.
module stbus_tx_bank
  import stbus_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [CH_W-1:0]   waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic              swap,
  input  logic [CH_W-1:0]   raddr,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [2][CHANNELS];
  logic              active;
  logic              wsel;
  logic              rsel;

  // The write bank is chosen from the pre-edge active bit, so a write on
  // the swap edge lands in the bank that becomes active on that edge.
  assign wsel = ~active;

  // The read side already looks at the post-swap bank, so the channel 0
  // byte loaded on the swap edge comes from the newly active bank.
  assign rsel  = active ^ swap;
  assign rdata = mem[rsel][raddr];

  // Store and active-bank pointer; reset refills both banks with idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < CHANNELS; c++) begin
          mem[b][c] <= IDLE_BYTE;
        end
      end
      active <= 1'b0;
    end else begin
      if (wr) begin
        mem[wsel][waddr] <= wdata;
      end
      if (swap) begin
        active <= ~active;
      end
    end
  end

endmodule

// File: rtl/stbus_frame_tx.sv
// ST-BUS frame master and serial transmitter. Generates C4, F0# and DSTo
// (32 channels x 8 bits, MSB first) from a double-buffered channel store.
// hcnt divides clk down to C4 half-periods; ph counts half-periods across
// the 1024-step frame. All line outputs are registered from the next-state
// value of ph, so they change on the same edge as the counters.
module stbus_frame_tx
  import stbus_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  stbus_frame_tx_if.master bus
);

  localparam int                HCNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(DIV - 1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(PH_PER_FRAME - 1);

  tx_state_e         state;
  logic [HCNT_W-1:0] hcnt;
  logic [HCNT_W-1:0] hcnt_nxt;
  logic [PH_W-1:0]   ph;
  logic [PH_W-1:0]   ph_nxt;

  logic              pend_q;
  logic              c4_q;
  logic              f0_n_q;
  logic              dsto_q;
  logic              tick_q;
  logic [CH_W-1:0]   chan_q;
  logic [BYTE_W-1:0] shreg;
  logic [BYTE_W-1:0] rd_byte;

  logic              start;    // first edge with en sampled high
  logic              adv;      // ph advances on this edge
  logic              wrap;     // ph goes 1023 -> 0 on this edge
  logic              swap;     // bank swap on this edge
  logic              load;     // ph becomes 32k: load channel k byte
  logic              shift_en; // ph becomes 4n inside a channel: next bit

  // Next-state decode of the timing counters and the data path strobes.
  always_comb begin
    start    = 1'b0;
    adv      = 1'b0;
    wrap     = 1'b0;
    swap     = 1'b0;
    load     = 1'b0;
    shift_en = 1'b0;
    hcnt_nxt = hcnt;
    ph_nxt   = ph;

    if (bus.en) begin
      if (state == ST_IDLE) begin
        // Restart one half-period before the boundary so the very first
        // frame opens with a complete F0# pulse.
        start    = 1'b1;
        hcnt_nxt = '0;
        ph_nxt   = PH_LAST;
      end else if (hcnt == HCNT_LAST) begin
        adv      = 1'b1;
        hcnt_nxt = '0;
        ph_nxt   = ph + 1'b1;
      end else begin
        hcnt_nxt = hcnt + 1'b1;
      end
    end

    wrap     = adv && (ph == PH_LAST);
    swap     = wrap && pend_q;
    load     = adv && (ph_nxt[CHAN_LSB-1:0] == '0);
    shift_en = adv && (ph_nxt[CELL_LSB-1:0] == '0) && !load;
  end

  stbus_tx_bank u_bank (
    .clk   (clk),
    .reset (reset),
    .wr    (bus.wr),
    .waddr (bus.waddr),
    .wdata (bus.wdata),
    .swap  (swap),
    .raddr (ph_nxt[PH_W-1:PH_W-CH_W]),
    .rdata (rd_byte)
  );

  // Run state, counters, commit tracking, shifter and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      hcnt   <= '0;
      ph     <= '0;
      pend_q <= 1'b0;
      c4_q   <= 1'b1;
      f0_n_q <= 1'b1;
      dsto_q <= 1'b1;
      tick_q <= 1'b0;
      chan_q <= '0;
      shreg  <= IDLE_BYTE;
    end else begin
      state <= bus.en ? ST_RUN : ST_IDLE;
      hcnt  <= hcnt_nxt;
      ph    <= ph_nxt;

      // A commit on the swap edge itself arms the following boundary.
      pend_q <= bus.commit | (pend_q & ~swap);

      if (bus.en) begin
        c4_q   <= ph_nxt[0];
        f0_n_q <= !((ph_nxt == PH_LAST) || (ph_nxt == '0));
        tick_q <= wrap;
        chan_q <= ph_nxt[PH_W-1:PH_W-CH_W];
        if (start) begin
          // Half-period before the first boundary carries no data.
          dsto_q <= 1'b1;
        end else if (load) begin
          dsto_q <= rd_byte[BYTE_W-1];
          shreg  <= {rd_byte[BYTE_W-2:0], 1'b1};
        end else if (shift_en) begin
          dsto_q <= shreg[BYTE_W-1];
          shreg  <= {shreg[BYTE_W-2:0], 1'b1};
        end
      end else begin
        // Counters hold; line goes idle; chan keeps its last value.
        c4_q   <= 1'b1;
        f0_n_q <= 1'b1;
        dsto_q <= 1'b1;
        tick_q <= 1'b0;
      end
    end
  end

  assign bus.pend       = pend_q;
  assign bus.c4         = c4_q;
  assign bus.f0_n       = f0_n_q;
  assign bus.dsto       = dsto_q;
  assign bus.frame_tick = tick_q;
  assign bus.chan       = chan_q;
  assign bus.state      = state;

endmodule

// File: tb/tb_stbus_frame_tx.sv
// Self-checking bench for stbus_frame_tx. A time-based model (enabled-cycle
// count -> ph, frame byte snapshot per channel) predicts every output on
// every cycle; directed scenarios add literal expectations on top.
module tb_stbus_frame_tx;
  import stbus_pkg::*;

  localparam int DIV        = 2;
  localparam int FRAME_CLKS = PH_PER_FRAME * DIV;
  localparam int CELL_CLKS  = PH_PER_BIT * DIV;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  stbus_frame_tx_if bus ();

  stbus_frame_tx #(.DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_bank [2][32];
  logic [7:0] m_fb [32];      // bytes being shown in the current frame
  bit         m_active, m_pend, m_run, m_on, m_valid;
  int         m_t;            // edges since en was first seen high
  int         m_ph;
  bit         e_c4, e_f0n, e_dsto, e_tick;
  logic [4:0] e_chan;

  always @(posedge clk) begin : model
    int ph;
    bit step, boundary, swap, na;
    m_valid = 1'b1;
    if (!reset) begin
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 32; c++) m_bank[b][c] = 8'hFF;
      for (int c = 0; c < 32; c++) m_fb[c] = 8'hFF;
      m_active = 0; m_pend = 0; m_run = 0; m_on = 0; m_t = 0; m_ph = 0;
      e_c4 = 1; e_f0n = 1; e_dsto = 1; e_tick = 0; e_chan = '0;
    end else begin
      boundary = 0;
      step     = 0;
      if (bus.en) begin
        if (!m_run) begin m_run = 1; m_t = 0; end
        else m_t++;
        ph       = (PH_PER_FRAME - 1 + m_t / DIV) % PH_PER_FRAME;
        step     = (m_t > 0) && (m_t % DIV == 0);
        boundary = step && (ph == 0);
      end else begin
        m_run = 0;
        ph    = m_ph;
      end
      swap = boundary && m_pend;
      na   = m_active ^ swap;
      if (step && (ph % 32 == 0)) m_fb[ph / 32] = m_bank[na][ph / 32];
      if (bus.wr) m_bank[!m_active][bus.waddr] = bus.wdata;
      m_pend   = bus.commit || (m_pend && !swap);
      m_active = na;
      m_ph     = ph;
      m_on     = bus.en;
      if (bus.en) begin
        e_c4   = (ph % 2) == 1;
        e_f0n  = !((ph == PH_PER_FRAME - 1) || (ph == 0));
        e_tick = boundary;
        e_chan = 5'(ph / 32);
        e_dsto = (m_t >= DIV) ? m_fb[ph / 32][7 - (ph / 4) % 8] : 1'b1;
      end else begin
        e_c4 = 1; e_f0n = 1; e_dsto = 1; e_tick = 0;
      end
    end
  end

  // Every-cycle compare of the DUT against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("outputs{c4,f0_n,dsto,tick,pend}",
            32'({bus.c4, bus.f0_n, bus.dsto, bus.frame_tick, bus.pend}),
            32'({e_c4, e_f0n, e_dsto, e_tick, m_pend}));
      if (m_on) check("chan", 32'(bus.chan), 32'(e_chan));
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] cap [32];
  logic [4:0] chan_last;

  task automatic write_ch(input int ch, input logic [7:0] d);
    bus.wr = 1'b1; bus.waddr = 5'(ch); bus.wdata = d;
    @(negedge clk);
    bus.wr = 1'b0;
  endtask

  task automatic pulse_commit();
    bus.commit = 1'b1;
    @(negedge clk);
    bus.commit = 1'b0;
  endtask

  task automatic wait_tick();
    int k = 0;
    do begin @(negedge clk); k++; end
    while (!bus.frame_tick && k < 3 * FRAME_CLKS);
    check("frame_tick_seen", 32'(bus.frame_tick), 32'd1);
  endtask

  // Starts at a tick negedge (optionally waiting for one) and samples the
  // middle of every bit cell of that frame.
  task automatic collect_frame(input bit wait_first);
    if (wait_first) wait_tick();
    for (int k = 0; k < FRAME_CLKS; k++) begin
      if (k > 0) @(negedge clk);
      if (k % CELL_CLKS == CELL_CLKS / 2) begin
        int n;
        n = k / CELL_CLKS;
        cap[n / 8][7 - (n % 8)] = bus.dsto;
        if (n == 255) chan_last = bus.chan;
      end
    end
  endtask

  task automatic wait_model_ph(input int ph, input bit pre_step);
    int k = 0;
    while (!(m_on && m_ph == ph && (!pre_step || (m_t % DIV == DIV - 1))) && k < 3 * FRAME_CLKS) begin
      @(negedge clk); k++;
    end
    check("model_ph_reached", 32'(m_ph), 32'(ph));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k, f0low, c4hi, f0fall, zeros, off;
    bus.en = 1'b1; bus.wr = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.commit = 1'b0;

    // Test 1: reset held with en=1
    repeat (3) @(negedge clk);
    check("rst_c4", 32'(bus.c4), 32'd1);
    check("rst_f0_n", 32'(bus.f0_n), 32'd1);
    check("rst_dsto", 32'(bus.dsto), 32'd1);
    check("rst_tick", 32'(bus.frame_tick), 32'd0);
    check("rst_pend", 32'(bus.pend), 32'd0);
    check("rst_chan", 32'(bus.chan), 32'd0);
    check("rst_state", 32'(bus.state), 32'(ST_IDLE));
    reset = 1'b1;
    @(negedge clk);
    check("start_f0_n_low", 32'(bus.f0_n), 32'd0);
    check("start_state", 32'(bus.state), 32'(ST_RUN));

    // Test 2: frame timing over one full frame
    wait_tick();
    k = 0; f0low = 0; c4hi = 0; f0fall = -1; zeros = 0;
    forever begin
      f0low += !bus.f0_n;
      c4hi  += bus.c4;
      zeros += !bus.dsto;
      if (k > 2 && !bus.f0_n && f0fall < 0) f0fall = k;
      @(negedge clk); k++;
      if (bus.frame_tick || k >= 3 * FRAME_CLKS) break;
    end
    check("tick_period", 32'(k), 32'd2048);
    check("f0_low_clks", 32'(f0low), 32'd4);
    check("c4_high_clks", 32'(c4hi), 32'd1024);
    check("f0_fall_to_tick", 32'(k - f0fall), 32'd2);
    check("idle_zero_bits", 32'(zeros), 32'd0);
    @(negedge clk);
    check("tick_one_clk", 32'(bus.frame_tick), 32'd0);

    // Test 3: ch0/ch31 through a commit
    write_ch(0, 8'hA5);
    write_ch(31, 8'h3C);
    pulse_commit();
    check("pend_after_commit", 32'(bus.pend), 32'd1);
    collect_frame(1);
    check("t3_ch0", 32'(cap[0]), 32'hA5);
    check("t3_ch31", 32'(cap[31]), 32'h3C);
    check("t3_ch5", 32'(cap[5]), 32'hFF);
    check("t3_chan_last", 32'(chan_last), 32'd31);
    check("t3_pend_clear", 32'(bus.pend), 32'd0);
    check("model_fb0", 32'(m_fb[0]), 32'hA5);

    // Test 4: write without commit stays invisible
    write_ch(5, 8'h00);
    collect_frame(1);
    check("t4_ch5_f1", 32'(cap[5]), 32'hFF);
    collect_frame(1);
    check("t4_ch5_f2", 32'(cap[5]), 32'hFF);
    check("t4_pend", 32'(bus.pend), 32'd0);
    repeat (4) @(negedge clk);
    pulse_commit();
    collect_frame(1);
    check("t4_ch5_new", 32'(cap[5]), 32'h00);
    check("t4_ch0_new", 32'(cap[0]), 32'hFF);
    check("t4_ch31_new", 32'(cap[31]), 32'hFF);

    // Test 5: commit exactly on the wrap edge while a swap is pending
    repeat (4) @(negedge clk);
    pulse_commit();
    wait_model_ph(PH_PER_FRAME - 1, 1);
    pulse_commit();
    check("t5_tick", 32'(bus.frame_tick), 32'd1);
    check("t5_pend_kept", 32'(bus.pend), 32'd1);
    collect_frame(0);
    check("t5_ch0", 32'(cap[0]), 32'hA5);
    check("t5_ch31", 32'(cap[31]), 32'h3C);
    check("t5_pend_frame_end", 32'(bus.pend), 32'd1);
    wait_tick();
    check("t5_pend_clear", 32'(bus.pend), 32'd0);
    collect_frame(0);
    check("t5_ch5_back", 32'(cap[5]), 32'h00);
    check("t5_ch0_back", 32'(cap[0]), 32'hFF);

    // Random traffic with occasional enable drops
    off = 0;
    for (int i = 0; i < 8 * FRAME_CLKS; i++) begin
      bus.wr     = ($urandom_range(0, 31) == 0);
      bus.waddr  = 5'($urandom_range(0, 31));
      bus.wdata  = 8'($urandom_range(0, 255));
      bus.commit = ($urandom_range(0, 1499) == 0);
      if (off > 0) begin
        off--;
        bus.en = 1'b0;
      end else begin
        bus.en = 1'b1;
        if ($urandom_range(0, 2999) == 0) off = $urandom_range(1, 60);
      end
      @(negedge clk);
    end
    bus.wr = 1'b0; bus.commit = 1'b0; bus.en = 1'b1;

    // Test 6: reset in the middle of a frame
    write_ch(5, 8'h5A);
    pulse_commit();
    wait_model_ph(500, 0);
    reset = 1'b0;
    @(negedge clk);
    check("t6_c4", 32'(bus.c4), 32'd1);
    check("t6_f0_n", 32'(bus.f0_n), 32'd1);
    check("t6_dsto", 32'(bus.dsto), 32'd1);
    check("t6_pend", 32'(bus.pend), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("t6_f0_restart", 32'(bus.f0_n), 32'd0);
    collect_frame(1);
    check("t6_ch0", 32'(cap[0]), 32'hFF);
    check("t6_ch5", 32'(cap[5]), 32'hFF);
    check("t6_ch31", 32'(cap[31]), 32'hFF);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
